// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the slice-serial wide adder (adder_seq_ctrl).
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index counter; never narrower than one bit.
  function automatic int idx_w(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/adder_n_bit.sv
// N-bit ripple-carry adder slice, time-shared by adder_seq_ctrl.
module adder_n_bit #(
  parameter int N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin : ripple
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder that reuses one N-bit slice over SLICES cycles, valid/ready on both ends.
// Optional signed-overflow output res_ovf is enabled by defining ADDER_SEQ_OVF_EN.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int N      = 3,
  parameter int SLICES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [N*SLICES-1:0]   op_a,
  input  logic [N*SLICES-1:0]   op_b,
  input  logic                  op_cin,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [N*SLICES-1:0]   res_sum,
  output logic                  res_cout,
`ifdef ADDER_SEQ_OVF_EN
  output logic                  res_ovf,
`endif
  output logic                  busy
);

  localparam int W  = N * SLICES;
  localparam int IW = idx_w(SLICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(SLICES - 1);

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg, sum_reg;
  logic            carry_reg, cout_reg;
  logic [IW-1:0]   idx_reg;
  logic [N-1:0]    slice_sum;
  logic            slice_cout;
  logic            last_slice;

  assign last_slice = (idx_reg == LAST_IDX);

  adder_n_bit #(.N(N)) u_slice (
    .a    (a_reg[N-1:0]),
    .b    (b_reg[N-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_valid) state_next = RUN;
      RUN:     if (last_slice)  state_next = DONE;
      DONE:    if (res_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_reg == IDLE);
    res_valid   = (state_reg == DONE);
    busy        = (state_reg == RUN) || (state_reg == DONE);
  end

  // Operands shift right so the active slice always sits in the low N bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= op_cin;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx_reg*N +: N] <= slice_sum;
          carry_reg <= slice_cout;
          a_reg     <= a_reg >> N;
          b_reg     <= b_reg >> N;
          idx_reg   <= last_slice ? '0 : idx_reg + 1'b1;
          if (last_slice) cout_reg <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign res_sum  = sum_reg;
  assign res_cout = cout_reg;

`ifdef ADDER_SEQ_OVF_EN
  logic ovf_reg;

  // On the final slice the low N bits hold the operand MSB slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == RUN && last_slice) begin
      ovf_reg <= (a_reg[N-1] == b_reg[N-1]) && (slice_sum[N-1] != a_reg[N-1]);
    end
  end

  assign res_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl (N=3, SLICES=4).
module tb_adder_seq_ctrl;

  localparam int N      = 3;
  localparam int SLICES = 4;
  localparam int W      = N * SLICES;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         busy;
`ifdef ADDER_SEQ_OVF_EN
  logic         res_ovf;
`endif

  int total = 0;
  int bad   = 0;

  adder_seq_ctrl #(.N(N), .SLICES(SLICES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_cout    (res_cout),
`ifdef ADDER_SEQ_OVF_EN
    .res_ovf     (res_ovf),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Present a request in IDLE; returns #1 after the accepting edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    op_cin      = cin;
    chk("accept_ready", {31'd0, start_ready}, 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    op_a        = W'($urandom);
    op_b        = W'($urandom);
    op_cin      = 1'($urandom);
  endtask

  // Checks exact latency: low after SLICES-1 edges, high after SLICES edges.
  task automatic wait_result(input string tag, input logic [W-1:0] exp_sum,
                             input logic exp_cout, input logic exp_ovf);
    repeat (SLICES - 1) @(posedge clk);
    #1;
    chk({tag, "_valid_early"}, {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_sum"},   {20'd0, res_sum},   {20'd0, exp_sum});
    chk({tag, "_cout"},  {31'd0, res_cout},  {31'd0, exp_cout});
    chk({tag, "_busy"},  {31'd0, busy},      32'd1);
`ifdef ADDER_SEQ_OVF_EN
    chk({tag, "_ovf"},   {31'd0, res_ovf},   {31'd0, exp_ovf});
`endif
  endtask

  task automatic release_result(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, res_valid},   32'd0);
    chk({tag, "_idle_ready"}, {31'd0, start_ready}, 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    op_cin      = 1'b0;
    res_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_res_valid",   {31'd0, res_valid},   32'd0);
    chk("rst_res_sum",     {20'd0, res_sum},     32'h000);
    chk("rst_res_cout",    {31'd0, res_cout},    32'd0);
    chk("rst_busy",        {31'd0, busy},        32'd0);
`ifdef ADDER_SEQ_OVF_EN
    chk("rst_res_ovf",     {31'd0, res_ovf},     32'd0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    accept(12'h00F, 12'h001, 1'b0);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_ready", {31'd0, start_ready}, 32'd0);
    wait_result("t00f", 12'h010, 1'b0, 1'b0);
    release_result("t00f");

    accept(12'hFFF, 12'h001, 1'b0);
    wait_result("tfff", 12'h000, 1'b1, 1'b0);
    release_result("tfff");

    accept(12'h7FF, 12'h000, 1'b1);
    wait_result("t7ff", 12'h800, 1'b0, 1'b1);
    release_result("t7ff");

    // Backpressure: result held while a new request waits.
    accept(12'h5A5, 12'h3C3, 1'b1);
    wait_result("t5a5", 12'h969, 1'b0, 1'b1);
    start_valid = 1'b1;
    op_a        = 12'h100;
    op_b        = 12'h022;
    op_cin      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_sum",   {20'd0, res_sum},     32'h969);
      chk("hold_ready", {31'd0, start_ready}, 32'd0);
    end
    chk("hold_valid", {31'd0, res_valid}, 32'd1);
    release_result("t5a5");
    chk("idle_gap_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("queued_accept_busy", {31'd0, busy}, 32'd1);
    wait_result("t100", 12'h122, 1'b0, 1'b0);
    release_result("t100");

    // Reset in the middle of RUN with idx=2.
    accept(12'h123, 12'h456, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("midrst_res_valid",   {31'd0, res_valid},   32'd0);
    chk("midrst_res_sum",     {20'd0, res_sum},     32'h000);
    chk("midrst_res_cout",    {31'd0, res_cout},    32'd0);
    chk("midrst_busy",        {31'd0, busy},        32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_midrst_valid", {31'd0, res_valid}, 32'd0);
    accept(12'h001, 12'h001, 1'b0);
    wait_result("t001", 12'h002, 1'b0, 1'b0);
    release_result("t001");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencer that performs wide W = N*SLICES bit additions by time-sharing one N-bit ripple adder slice (adder_n_bit) over SLICES cycles.
- Carry is chained between slices through an internal carry register.
- Operands are accepted on a valid/ready request port; results are returned on a valid/ready response port.
- Sits between a wide-operand producer and consumer where area matters more than latency.

Parameters:
N, 3, width of the shared adder slice in bits (>=1)
SLICES, 4, number of slices per operation (>=2); operand width W = N*SLICES

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  request: operands valid
start_ready  out  1  request: block can accept
op_a  in  W  operand A
op_b  in  W  operand B
op_cin  in  1  carry-in for slice 0
res_valid  out  1  response: result valid
res_ready  in  1  response: consumer accepts
res_sum  out  W  result sum
res_cout  out  1  carry-out of final slice
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, start_ready=1, res_valid=0, res_sum=0, res_cout=0, busy=0, slice index=0, carry register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready edge: latch op_a, op_b into shift registers; carry register := op_cin; idx := 0; go to RUN.
- RUN:
  - start_ready=0.
  - Each cycle, the slice adds the low N bits of the A and B shift registers plus the carry register.
  - On the edge: write the sum slice into res_sum[idx*N +: N]; carry register := slice cout; shift both operand registers right by N; idx++.
  - When idx==SLICES-1 on that edge: go to DONE and set res_cout := slice cout.
- Latency: res_valid rises exactly SLICES clock edges after the accepting edge. For SLICES=4: accept at edge 0, res_valid high after edge 4.
- DONE:
  - res_valid=1; res_sum and res_cout held stable.
  - On res_ready edge: go to IDLE; res_valid := 0. res_sum keeps its last value until the next write.
- No same-cycle restart: start_ready is 0 in DONE, so a new request is accepted at the earliest one cycle after the result handshake.
- Inputs op_a, op_b and op_cin are don't-care outside the accepting cycle. start_valid is ignored while start_ready=0.
- Arithmetic: unsigned modulo 2^W; {res_cout,res_sum} = op_a + op_b + op_cin exactly.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no res_valid is emitted.

Optional Feature:
ADDER_SEQ_OVF_EN
- Defined: adds output port res_ovf (1 bit). It is the signed two's-complement overflow of the W-bit add, computed as (a_msb==b_msb) && (sum_msb!=a_msb).
  - a_msb and b_msb are captured during the final RUN cycle.
  - res_ovf is registered with res_cout, valid while res_valid=1, and reset to 0.
- Undefined: port and logic absent; no other behaviour changes.

Decomposition:
- Package adder_seq_pkg: state enum type (IDLE, RUN, DONE) and a localparam function returning the idx width $clog2(SLICES).
- One sub-module: adder_n_bit #(.N(N)) instantiated once as the shared slice.
- Controller FSM, shift registers and carry register stay in adder_seq_ctrl.

Test Plan:
- Reset with no stimulus -> start_ready=1, res_valid=0, res_sum=0x000, res_cout=0, busy=0.
- N=3, SLICES=4: op_a=0x00F, op_b=0x001, op_cin=0 -> res_sum=0x010, res_cout=0; res_valid high exactly 4 edges after accept.
- op_a=0xFFF, op_b=0x001, op_cin=0 -> res_sum=0x000, res_cout=1 (carry propagates through all 4 slices); with ADDER_SEQ_OVF_EN, res_ovf=0.
- op_a=0x7FF, op_b=0x000, op_cin=1 -> res_sum=0x800, res_cout=0; with ADDER_SEQ_OVF_EN, res_ovf=1.
- op_a=0x5A5, op_b=0x3C3, op_cin=1, then res_ready held low 5 cycles while start_valid=1 with new operands -> res_sum=0x969 stable, start_ready=0, new operands not taken. After res_ready=1, one idle cycle, then the new request is accepted.
- Assert rst_n=0 during RUN at idx=2 -> outputs return to reset values immediately, no res_valid. After release, op_a=0x001, op_b=0x001 -> res_sum=0x002.
